// File: rtl/flash_boot_reader.sv
// SPI-flash boot reader: wakes the flash after reset, then serves 32-bit
// little-endian word reads using the READ opcode (mode 0, 24-bit address).
module flash_boot_reader #(
    parameter int         CLK_DIV  = 1,
    parameter logic [7:0] WAKE_CMD = 8'hAB,
    parameter logic [7:0] READ_CMD = 8'h03
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int GW = $clog2(2 * CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_WAKE, S_WGAP, S_IDLE, S_CMD, S_ADDR, S_DATA, S_GAP
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [5:0]    bit_q, bit_d;
    logic          sck_q, sck_d;
    logic          csb_q, csb_d;
    logic          io0_q, io0_d;
    logic [31:0]   sout_q, sout_d;
    logic [31:0]   sin_q, sin_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_data_q, rsp_data_d;

    logic shifting, tick, rise, fall, gap_end;
    logic wake_start, accept, frame_end, rsp_first;

    // SCK only runs while a frame is open; csb_q high in WAKE means the
    // wake frame has not started yet.
    assign shifting   = (state_q inside {S_WAKE, S_CMD, S_ADDR, S_DATA}) && !csb_q;
    assign tick       = (div_q == DIV_LAST);
    assign rise       = shifting && tick && !sck_q;
    assign fall       = shifting && tick && sck_q;
    assign gap_end    = (gap_q == GAP_LAST);
    assign wake_start = (state_q == S_WAKE) && csb_q;
    assign accept     = (state_q == S_IDLE) && req_valid;
    assign frame_end  = fall && (((state_q == S_WAKE) && (bit_q == 6'd7)) ||
                                 ((state_q == S_DATA) && (bit_q == 6'd63)));
    assign rsp_first  = (state_q == S_GAP) && (gap_q == '0);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) state_q <= S_WAKE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAKE:        if (fall && bit_q == 6'd7)  state_d = S_WGAP;
            S_WGAP, S_GAP: if (gap_end)                state_d = S_IDLE;
            S_IDLE:        if (req_valid)              state_d = S_CMD;
            S_CMD:         if (fall && bit_q == 6'd7)  state_d = S_ADDR;
            S_ADDR:        if (fall && bit_q == 6'd31) state_d = S_DATA;
            S_DATA:        if (fall && bit_q == 6'd63) state_d = S_GAP;
            default:                                   state_d = S_WAKE;
        endcase
    end

    always_comb begin
        req_ready   = (state_q == S_IDLE);
        div_d       = shifting ? (tick ? '0 : div_q + DW'(1)) : '0;
        gap_d       = ((state_q == S_WGAP || state_q == S_GAP) && !gap_end) ? gap_q + GW'(1) : '0;
        sck_d       = (shifting && tick) ? ~sck_q : sck_q;
        csb_d       = csb_q;
        bit_d       = bit_q;
        sout_d      = sout_q;
        sin_d       = sin_q;
        rsp_valid_d = rsp_first;
        rsp_data_d  = rsp_data_q;

        if (wake_start || accept) begin
            csb_d  = 1'b0;
            bit_d  = '0;
            sout_d = wake_start ? {WAKE_CMD, 24'h0} : {READ_CMD, req_addr};
        end else if (fall) begin
            bit_d  = bit_q + 6'd1;
            sout_d = {sout_q[30:0], 1'b0};
            if (frame_end) csb_d = 1'b1;
        end
        if (rise && state_q == S_DATA) sin_d = {sin_q[30:0], flash_io1};
        // Zeros shift in behind the address, so io0 is already low in DATA.
        io0_d = csb_d ? 1'b0 : sout_d[31];
        if (rsp_first) rsp_data_d = {sin_q[7:0], sin_q[15:8], sin_q[23:16], sin_q[31:24]};
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            div_q       <= '0;
            gap_q       <= '0;
            bit_q       <= '0;
            sck_q       <= 1'b0;
            csb_q       <= 1'b1;
            io0_q       <= 1'b0;
            sout_q      <= '0;
            sin_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            div_q       <= div_d;
            gap_q       <= gap_d;
            bit_q       <= bit_d;
            sck_q       <= sck_d;
            csb_q       <= csb_d;
            io0_q       <= io0_d;
            sout_q      <= sout_d;
            sin_q       <= sin_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign flash_csb = csb_q;
    assign flash_clk = sck_q;
    assign flash_io0 = io0_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_flash_boot_reader.sv
// Bench for flash_boot_reader: two instances (CLK_DIV=1 and 3) against a
// behavioural serial-flash model and a word-level read scoreboard.
module tb_flash_boot_reader;

    logic        clock = 1'b0;
    logic        resetb;
    logic        req_valid [2];
    logic [23:0] req_addr  [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_data  [2];
    logic        csb [2];
    logic        sck [2];
    logic        io0 [2];
    logic        io1 [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // monitor / flash-model state per instance
    int          rises [2];
    logic [63:0] mosi [2];
    logic [23:0] faddr [2];
    logic        p_csb [2], p_sck [2], p_rdy [2], p_rv [2];
    int          run [2];
    int          csb_rise_cyc [2];
    logic        expect_wake [2];
    logic        pend [2];
    int          pend_cyc [2];
    logic [23:0] pend_addr [2];
    int          rsp_cnt [2];
    int          wake_frames [2];
    int          last_rises [2];
    int          last_lat [2];
    logic [31:0] last_rsp [2];
    logic [7:0]  last_wake [2];

    flash_boot_reader #(.CLK_DIV(1)) u_d1 (
        .clock(clock), .resetb(resetb),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
        .flash_csb(csb[0]), .flash_clk(sck[0]), .flash_io0(io0[0]), .flash_io1(io1[0])
    );

    flash_boot_reader #(.CLK_DIV(3)) u_d3 (
        .clock(clock), .resetb(resetb),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
        .flash_csb(csb[1]), .flash_clk(sck[1]), .flash_io0(io0[1]), .flash_io1(io1[1])
    );

    always #5 clock = ~clock;

    function automatic int dv(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    // flash contents: a few fixed bytes at the bottom, a hash elsewhere
    function automatic logic [7:0] fbyte(input logic [23:0] a);
        case (a)
            24'd0:        return 8'h6F;
            24'd1, 24'd2: return 8'h00;
            24'd3:        return 8'h0B;
            default:      return (a[7:0] * 8'd29) ^ a[15:8] ^ a[23:16] ^ 8'hC3;
        endcase
    endfunction

    function automatic logic [31:0] model_word(input logic [23:0] a);
        return {fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon_one(input int g);
        logic [7:0] b;
        int j;
        if (!resetb) begin
            chk("rst_csb", 64'(csb[g]), 64'd1);
            chk("rst_sck", 64'(sck[g]), 64'd0);
            chk("rst_io0", 64'(io0[g]), 64'd0);
            chk("rst_ready", 64'(req_ready[g]), 64'd0);
            chk("rst_rsp_valid", 64'(rsp_valid[g]), 64'd0);
            chk("rst_rsp_data", 64'(rsp_data[g]), 64'd0);
            pend[g] = 1'b0; expect_wake[g] = 1'b1; rises[g] = 0; mosi[g] = '0;
            io1[g] = 1'b0; p_csb[g] = 1'b1; p_sck[g] = 1'b0; p_rdy[g] = 1'b0;
            p_rv[g] = 1'b0; run[g] = 0; csb_rise_cyc[g] = cyc;
            return;
        end
        if (csb[g]) begin
            chk("idle_io0", 64'(io0[g]), 64'd0);
            chk("idle_sck", 64'(sck[g]), 64'd0);
        end else begin
            chk("ready_while_busy", 64'(req_ready[g]), 64'd0);
        end
        if (sck[g] != p_sck[g]) begin
            if (!p_csb[g] && !(sck[g] && rises[g] == 0))
                chk("sck_phase", 64'(run[g]), 64'(dv(g)));
            run[g] = 1;
        end else begin
            run[g]++;
        end
        if (!csb[g] && p_csb[g]) begin
            rises[g] = 0;
            mosi[g]  = '0;
            if (!expect_wake[g]) chk("frame_without_request", 64'(pend[g]), 64'd1);
        end
        if (!csb[g] && sck[g] && !p_sck[g]) begin
            rises[g]++;
            mosi[g] = {mosi[g][62:0], io0[g]};
            if (rises[g] == 32) faddr[g] = mosi[g][23:0];
        end
        // flash shifts the next data bit out after each falling edge
        if (!csb[g] && !sck[g] && p_sck[g] && rises[g] >= 32 && rises[g] < 64) begin
            j = rises[g] - 32;
            b = fbyte(faddr[g] + 24'(j / 8));
            io1[g] = b[3'(7 - (j % 8))];
        end
        if (csb[g] && !p_csb[g]) begin
            last_rises[g] = rises[g];
            if (expect_wake[g]) begin
                chk("wake_sck_count", 64'(rises[g]), 64'd8);
                chk("wake_mosi", mosi[g], 64'hAB);
                last_wake[g] = mosi[g][7:0];
                wake_frames[g]++;
                expect_wake[g] = 1'b0;
            end else begin
                chk("read_sck_count", 64'(rises[g]), 64'd64);
                chk("read_mosi", mosi[g], {8'h03, pend_addr[g], 32'h0});
            end
            csb_rise_cyc[g] = cyc;
            io1[g] = 1'b0;
        end
        if (req_ready[g] && !p_rdy[g])
            chk("ready_after_deselect", 64'(cyc - csb_rise_cyc[g]), 64'(2 * dv(g)));
        if (rsp_valid[g]) begin
            chk("rsp_single_pulse", 64'(p_rv[g]), 64'd0);
            chk("rsp_has_request", 64'(pend[g]), 64'd1);
            if (pend[g]) begin
                last_lat[g] = cyc - pend_cyc[g];
                last_rsp[g] = rsp_data[g];
                chk("rsp_latency", 64'(last_lat[g]), 64'(128 * dv(g) + 2));
                chk("rsp_data", 64'(rsp_data[g]), 64'(model_word(pend_addr[g])));
                pend[g] = 1'b0;
                rsp_cnt[g]++;
            end
        end
        if (req_valid[g] && req_ready[g]) begin
            chk("accept_while_pending", 64'(pend[g]), 64'd0);
            chk("accept_after_gap", 64'(cyc - csb_rise_cyc[g] >= 2 * dv(g)), 64'd1);
            pend[g] = 1'b1;
            pend_cyc[g] = cyc;
            pend_addr[g] = req_addr[g];
        end
        p_csb[g] = csb[g];
        p_sck[g] = sck[g];
        p_rdy[g] = req_ready[g];
        p_rv[g]  = rsp_valid[g];
    endtask

    task automatic monitor();
        forever begin
            @(negedge clock);
            cyc++;
            for (int g = 0; g < 2; g++) mon_one(g);
        end
    endtask

    task automatic wait_ready(input int g);
        for (int n = 0; n < 1000 && !req_ready[g]; n++) @(negedge clock);
        chk("ready_timeout", 64'(req_ready[g]), 64'd1);
    endtask

    task automatic do_req(input int g, input logic [23:0] a);
        logic got;
        got = 1'b0;
        @(posedge clock); #1;
        req_valid[g] = 1'b1;
        req_addr[g]  = a;
        for (int n = 0; n < 2000 && !got; n++) begin
            @(negedge clock);
            got = req_ready[g];
        end
        chk("accept_timeout", 64'(got), 64'd1);
        @(posedge clock); #1;
        req_valid[g] = 1'b0;
    endtask

    task automatic wait_rsp(input int g, input int n);
        for (int k = 0; k < 3000 && rsp_cnt[g] < n; k++) @(posedge clock);
        chk("rsp_timeout", 64'(rsp_cnt[g] >= n), 64'd1);
    endtask

    initial begin
        int rc, wf;
        logic hit;
        resetb = 1'b1;
        for (int g = 0; g < 2; g++) begin
            req_valid[g] = 1'b0; req_addr[g] = '0; io1[g] = 1'b0;
            rsp_cnt[g] = 0; wake_frames[g] = 0; last_rises[g] = 0;
            last_lat[g] = 0; last_rsp[g] = '0; last_wake[g] = '0;
        end
        #2 resetb = 1'b0;
        fork monitor(); join_none
        repeat (3) @(posedge clock);
        #1 resetb = 1'b1;

        wait_ready(0);
        wait_ready(1);
        chk("wake_byte_d1", 64'(last_wake[0]), 64'hAB);
        chk("wake_frames_d1", 64'(wake_frames[0]), 64'd1);
        chk("wake_byte_d3", 64'(last_wake[1]), 64'hAB);

        do_req(0, 24'h000000);
        wait_rsp(0, 1);
        chk("read0_word", 64'(last_rsp[0]), 64'h0B00006F);
        chk("read0_latency", 64'(last_lat[0]), 64'd130);

        do_req(0, 24'h123456);
        wait_rsp(0, 2);
        chk("read123456_sck", 64'(last_rises[0]), 64'd64);
        chk("read123456_latency", 64'(last_lat[0]), 64'd130);

        // back-to-back, first one wrapping past the top of the address space
        do_req(0, 24'hFFFFFE);
        do_req(0, 24'h000001);
        wait_rsp(0, 4);
        chk("b2b_second_word", 64'(last_rsp[0]), 64'hB70B0000);

        // reset pulse in the middle of the address phase
        do_req(0, 24'hABCDEF);
        hit = 1'b0;
        for (int n = 0; n < 200 && !hit; n++) begin
            @(posedge clock); #2;
            hit = (rises[0] >= 16) && sck[0] && !csb[0];
        end
        chk("reached_addr_phase", 64'(hit), 64'd1);
        rc = rsp_cnt[0];
        wf = wake_frames[0];
        resetb = 1'b0;
        #1;
        chk("async_rst_csb", 64'(csb[0]), 64'd1);
        chk("async_rst_sck", 64'(sck[0]), 64'd0);
        repeat (3) @(posedge clock);
        #1 resetb = 1'b1;
        wait_ready(0);
        wait_ready(1);
        chk("rewake_frames", 64'(wake_frames[0]), 64'(wf + 1));
        chk("no_rsp_after_reset", 64'(rsp_cnt[0]), 64'(rc));
        do_req(0, 24'h000010);
        wait_rsp(0, rc + 1);

        do_req(1, 24'h000000);
        wait_rsp(1, 1);
        chk("d3_read0_word", 64'(last_rsp[1]), 64'h0B00006F);
        chk("d3_read0_latency", 64'(last_lat[1]), 64'd386);
        do_req(1, 24'h123456);
        wait_rsp(1, 2);
        chk("d3_read123456_latency", 64'(last_lat[1]), 64'd386);

        repeat (5) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
